// File: rtl/fan_matrix_animator.sv
// fan_matrix_animator: scanned ROWS x COLS red/green dot-matrix animator.
// The block holds a host-writable frame memory and an internal frame-rate divider
// selected by 'level'. An internal row scanner drives the one-hot row outputs and
// the column outputs.
// Build option: define FAN_MATRIX_BOUNCE_EN to add the 'bounce' input. With that
// input high, the frame index ping-pongs instead of wrapping around.

module fan_matrix_animator #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int FRAMES   = 4,
  parameter int LVL_W    = 2,
  parameter int BASE_DIV = 50000000,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [LVL_W-1:0]          level,
  input  logic                      dir,
`ifdef FAN_MATRIX_BOUNCE_EN
  input  logic                      bounce,
`endif
  input  logic                      wr_en,
  input  logic [$clog2(FRAMES)-1:0] wr_frame,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [2*COLS-1:0]         wr_data,
  output logic [ROWS-1:0]           row_sel,
  output logic [COLS-1:0]           col_r,
  output logic [COLS-1:0]           col_g,
  output logic [$clog2(FRAMES)-1:0] frame_idx,
  output logic                      frame_tick
);

  localparam int FW     = $clog2(FRAMES);
  localparam int RW     = $clog2(ROWS);
  localparam int DIV_W  = $clog2(BASE_DIV + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [FW-1:0]     LAST_FRAME = FW'(FRAMES - 1);
  localparam logic [RW-1:0]     LAST_ROW   = RW'(ROWS - 1);
  localparam logic [SCAN_W-1:0] LAST_SCAN  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [ROWS-1:0]   ROW_ONE    = ROWS'(1);

  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [RW-1:0]     row_q, row_d;
  logic [FW-1:0]     disp_q, disp_d;
  logic [ROWS-1:0]   row_sel_q, row_sel_d;
  logic [COLS-1:0]   col_r_q, col_r_d;
  logic [COLS-1:0]   col_g_q, col_g_d;

  logic [2*COLS-1:0] mem_q [FRAMES][ROWS];

  logic [DIV_W-1:0]  period;
  logic [DIV_W-1:0]  periodLast;
  logic [2*COLS-1:0] rowData;
  logic              down;
  logic              wrOk;

`ifdef FAN_MATRIX_BOUNCE_EN
  logic bounce_q, bounce_d;
  logic bdir_q, bdir_d;
  logic bounceRise;
`endif

  // Step a frame index one place up or down, wrapping at either end.
  function automatic logic [FW-1:0] nextFrame(input logic [FW-1:0] cur, input logic goDown);
    if (goDown) return (cur == '0) ? LAST_FRAME : cur - FW'(1);
    return (cur == LAST_FRAME) ? '0 : cur + FW'(1);
  endfunction

  // Next-state logic for the divider, frame sequencing, row scanner and output registers.
  always_comb begin
    lvl_d     = level;
    div_d     = div_q;
    tick_d    = 1'b0;
    frame_d   = frame_q;
    scan_d    = scan_q;
    row_d     = row_q;
    disp_d    = disp_q;
    row_sel_d = '0;
    col_r_d   = '0;
    col_g_d   = '0;
    down      = dir;
`ifdef FAN_MATRIX_BOUNCE_EN
    bounce_d   = bounce;
    bdir_d     = bdir_q;
    bounceRise = bounce && !bounce_q;
    if (bounceRise) bdir_d = dir;
`endif
    period     = DIV_W'(BASE_DIV) >> (lvl_q - LVL_W'(1));
    periodLast = period - DIV_W'(1);
    rowData    = mem_q[disp_q][row_q];

    if (en) begin
      row_sel_d          = ROW_ONE << row_q;
      {col_r_d, col_g_d} = rowData;
      if (scan_q == LAST_SCAN) begin
        scan_d = '0;
        if (row_q == LAST_ROW) begin
          row_d  = '0;
          disp_d = frame_q;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        scan_d = scan_q + SCAN_W'(1);
      end
    end

    if (level != lvl_q) begin
      div_d = '0;
    end else if (en && lvl_q != '0) begin
      if (div_q == periodLast) begin
        div_d  = '0;
        tick_d = 1'b1;
`ifdef FAN_MATRIX_BOUNCE_EN
        if (bounce) begin
          down = bounceRise ? dir : bdir_q;
          if (!down && frame_q == LAST_FRAME) down = 1'b1;
          else if (down && frame_q == '0) down = 1'b0;
          bdir_d = down;
        end
`endif
        frame_d = nextFrame(frame_q, down);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (en && lvl_q == '0) frame_d = '0;
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q     <= '0;
      div_q     <= '0;
      tick_q    <= 1'b0;
      frame_q   <= '0;
      scan_q    <= '0;
      row_q     <= '0;
      disp_q    <= '0;
      row_sel_q <= '0;
      col_r_q   <= '0;
      col_g_q   <= '0;
`ifdef FAN_MATRIX_BOUNCE_EN
      bounce_q  <= 1'b0;
      bdir_q    <= 1'b0;
`endif
    end else begin
      lvl_q     <= lvl_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
      scan_q    <= scan_d;
      row_q     <= row_d;
      disp_q    <= disp_d;
      row_sel_q <= row_sel_d;
      col_r_q   <= col_r_d;
      col_g_q   <= col_g_d;
`ifdef FAN_MATRIX_BOUNCE_EN
      bounce_q  <= bounce_d;
      bdir_q    <= bdir_d;
`endif
    end
  end

  assign wrOk = (int'(wr_frame) < FRAMES) && (int'(wr_row) < ROWS);

  // Frame memory: host writes land at the clock edge; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < FRAMES; f++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[f][r] <= '0;
        end
      end
    end else if (wr_en && wrOk) begin
      mem_q[wr_frame][wr_row] <= wr_data;
    end
  end

  assign row_sel    = row_sel_q;
  assign col_r      = col_r_q;
  assign col_g      = col_g_q;
  assign frame_idx  = frame_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_fan_matrix_animator.sv
// tb_fan_matrix_animator: directed and randomized checks of fan_matrix_animator
// against a cycle-level behavioural model of the matrix animator.

module tb_fan_matrix_animator;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int FRAMES   = 4;
  localparam int LVL_W    = 2;
  localparam int BASE_DIV = 16;
  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  level;
  logic        dir;
  logic        wr_en;
  logic [1:0]  wr_frame;
  logic [2:0]  wr_row;
  logic [15:0] wr_data;
  logic [7:0]  row_sel;
  logic [7:0]  col_r;
  logic [7:0]  col_g;
  logic [1:0]  frame_idx;
  logic        frame_tick;
`ifdef FAN_MATRIX_BOUNCE_EN
  logic        bounce;
  initial bounce = 1'b0;
`endif

  // Model state: level, divider count, frame, scan position over a whole frame, displayed frame.
  int          mLvl, mDiv, mFrame, mScanPos, mDisp;
  logic        mTick;
  logic [7:0]  mRowSel, mColR, mColG;
  logic [15:0] mMem [FRAMES][ROWS];

  int checks   = 0;
  int failures = 0;

  fan_matrix_animator #(
    .ROWS(ROWS), .COLS(COLS), .FRAMES(FRAMES), .LVL_W(LVL_W),
    .BASE_DIV(BASE_DIV), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .level(level), .dir(dir),
`ifdef FAN_MATRIX_BOUNCE_EN
    .bounce(bounce),
`endif
    .wr_en(wr_en), .wr_frame(wr_frame), .wr_row(wr_row), .wr_data(wr_data),
    .row_sel(row_sel), .col_r(col_r), .col_g(col_g),
    .frame_idx(frame_idx), .frame_tick(frame_tick)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mLvl = 0; mDiv = 0; mFrame = 0; mScanPos = 0; mDisp = 0; mTick = 1'b0;
    mRowSel = '0; mColR = '0; mColG = '0;
    for (int f = 0; f < FRAMES; f++)
      for (int r = 0; r < ROWS; r++) mMem[f][r] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelStep();
    int nDiv, nFrame, nScan, nDisp, row, period;
    logic nTick;
    logic [15:0] rd;
    nDiv = mDiv; nFrame = mFrame; nScan = mScanPos; nDisp = mDisp; nTick = 1'b0;
    if (en) begin
      row     = mScanPos / SCAN_DIV;
      mRowSel = 8'(1 << row);
      rd      = mMem[mDisp][row];
      mColR   = rd[15:8];
      mColG   = rd[7:0];
      nScan   = (mScanPos + 1) % (SCAN_DIV * ROWS);
      if (nScan == 0) nDisp = mFrame;
    end else begin
      mRowSel = '0; mColR = '0; mColG = '0;
    end
    if (int'(level) != mLvl) begin
      nDiv = 0;
    end else if (en && mLvl > 0) begin
      period = BASE_DIV / (1 << (mLvl - 1));
      if (mDiv == period - 1) begin
        nDiv   = 0;
        nTick  = 1'b1;
        nFrame = dir ? (mFrame + FRAMES - 1) % FRAMES : (mFrame + 1) % FRAMES;
      end else begin
        nDiv = mDiv + 1;
      end
    end
    if (en && mLvl == 0) nFrame = 0;
    if (wr_en) mMem[wr_frame][wr_row] = wr_data;
    mLvl = int'(level); mDiv = nDiv; mFrame = nFrame; mScanPos = nScan; mDisp = nDisp; mTick = nTick;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".row_sel"},    row_sel,    mRowSel);
    checkVal({tag, ".col_r"},      col_r,      mColR);
    checkVal({tag, ".col_g"},      col_g,      mColG);
    checkVal({tag, ".frame_idx"},  frame_idx,  mFrame);
    checkVal({tag, ".frame_tick"}, frame_tick, mTick);
  endtask

  // One clock: inputs were set at the preceding negedge; outputs are compared at the next negedge.
  task automatic applyStimulus();
    @(posedge clk);
    if (rst) modelReset();
    else modelStep();
    @(negedge clk);
    checkOutput("cycle");
  endtask

  // Clock until frame_tick is seen, returning how many cycles that took (bounded).
  task automatic waitTick(input string tag, input int bound, output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (frame_tick !== 1'b1 && n < bound);
    checkVal({tag, ".tick_seen"}, frame_tick, 1);
  endtask

  // Directed scenarios followed by a randomized soak, then a mid-run asynchronous reset.
  initial begin
    int n, held, ticks, nz;
    int seqUp [4];
    int seqDn [4];
    logic [15:0] d6;
    seqUp = '{1, 2, 3, 0};
    seqDn = '{3, 2, 1, 0};

    rst = 1'b1; en = 1'b0; level = 2'd0; dir = 1'b0;
    wr_en = 1'b0; wr_frame = '0; wr_row = '0; wr_data = '0;
    modelReset();
    repeat (2) applyStimulus();
    checkVal("reset.row_sel", row_sel, 0);
    checkVal("reset.frame_idx", frame_idx, 0);
    rst = 1'b0;

    // Fill memory with random content while idle at level 0.
    en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      wr_en    = 1'($urandom_range(0, 1));
      wr_frame = 2'($urandom_range(0, 3));
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      applyStimulus();
    end

    // Static image: frame 0 row 3 shows the written pattern for four cycles.
    wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'd3; wr_data = 16'h813C;
    applyStimulus();
    wr_en = 1'b0;
    n = 0;
    while (row_sel !== 8'h08 && n < 64) begin
      applyStimulus();
      n++;
    end
    checkVal("t5.row_sel", row_sel, 8'h08);
    checkVal("t5.col_r", col_r, 8'h81);
    checkVal("t5.col_g", col_g, 8'h3C);
    held = 1;
    repeat (10) begin
      applyStimulus();
      if (row_sel !== 8'h08) break;
      held++;
    end
    checkVal("t5.row_hold", held, 4);

    // Level 1 counting up: a tick every 16 cycles, frames 1,2,3,0.
    level = 2'd1; dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitTick("t2", 40, n);
      if (i > 0) checkVal("t2.gap", n, 16);
      checkVal("t2.frame", frame_idx, seqUp[i]);
    end

    // Back to the idle image, then level 3 counting down: a tick every 4 cycles, frames 3,2,1,0.
    level = 2'd0;
    repeat (3) applyStimulus();
    checkVal("t3.idle_frame", frame_idx, 0);
    level = 2'd3; dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitTick("t3", 20, n);
      if (i > 0) checkVal("t3.gap", n, 4);
      checkVal("t3.frame", frame_idx, seqDn[i]);
    end

    // A level change with the divider at 10 restarts it: the next tick comes 8 cycles later.
    level = 2'd1; dir = 1'b0;
    repeat (2) applyStimulus();
    n = 0;
    while (mDiv != 10 && n < 40) begin
      applyStimulus();
      n++;
    end
    level = 2'd2;
    applyStimulus();
    waitTick("t4", 20, n);
    checkVal("t4.gap", n, 8);

    // Randomized soak over enable, level, direction and writes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) level = 2'($urandom_range(0, 3));
      en       = ($urandom_range(0, 7) != 0);
      dir      = 1'($urandom_range(0, 1));
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_frame = 2'($urandom_range(0, 3));
      wr_row   = 3'($urandom_range(0, 7));
      wr_data  = 16'($urandom);
      applyStimulus();
    end

    // Level drop to 0 stops ticks and returns to frame 0; en=0 blanks the display.
    wr_en = 1'b0; en = 1'b1; level = 2'd2; dir = 1'b0;
    repeat (20) applyStimulus();
    level = 2'd0;
    repeat (2) applyStimulus();
    checkVal("t6.frame_idx", frame_idx, 0);
    ticks = 0;
    repeat (40) begin
      applyStimulus();
      if (frame_tick === 1'b1) ticks++;
    end
    checkVal("t6.no_ticks", ticks, 0);
    en = 1'b0;
    applyStimulus();
    checkVal("t6.off_row_sel", row_sel, 0);
    checkVal("t6.off_col_r", col_r, 0);
    checkVal("t6.off_col_g", col_g, 0);
    d6 = 16'($urandom) | 16'h0101;
    wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'd5; wr_data = d6;
    applyStimulus();
    wr_en = 1'b0;
    repeat (3) applyStimulus();
    en = 1'b1;
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (row_sel !== 8'h20 && n < 40);
    checkVal("t6.row_sel", row_sel, 8'h20);
    checkVal("t6.col_r", col_r, {24'd0, d6[15:8]});
    checkVal("t6.col_g", col_g, {24'd0, d6[7:0]});

    // Asynchronous reset mid-count at level 3 clears outputs at once and wipes memory.
    level = 2'd3;
    for (int r = 0; r < ROWS; r++) begin
      wr_en = 1'b1; wr_frame = 2'd0; wr_row = 3'(r); wr_data = 16'($urandom) | 16'h0001;
      applyStimulus();
    end
    wr_en = 1'b0;
    repeat (13) applyStimulus();
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t1.async");
    checkVal("t1.row_sel", row_sel, 0);
    checkVal("t1.col_r", col_r, 0);
    checkVal("t1.col_g", col_g, 0);
    checkVal("t1.frame_idx", frame_idx, 0);
    checkVal("t1.frame_tick", frame_tick, 0);
    applyStimulus();
    rst = 1'b0; level = 2'd0; en = 1'b1;
    nz = 0;
    repeat (40) begin
      applyStimulus();
      if (col_r !== 8'h00 || col_g !== 8'h00) nz++;
    end
    checkVal("t1.mem_zero", nz, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
